// File: rtl/fp_norm_pack.sv
// Normalize/round/pack back end of the 3-input float adder: 3-stage valid/ready pipeline.
// Define FP_NORM_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fp_norm_pack #(
   parameter int EXPONENT = 8,
   parameter int MANTISSA = 23,
   parameter int SUMW     = MANTISSA + 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [SUMW-1:0]              sum,
   input  logic [EXPONENT-1:0]          max_exp,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [EXPONENT+MANTISSA:0]   result,
   output logic                         flag_zero,
   output logic                         flag_ovf,
   output logic                         flag_unf
);

   localparam int PW = $clog2(SUMW);
   localparam int RW = EXPONENT + MANTISSA + 1;
   localparam logic [PW-1:0]          TOP_IDX  = PW'(SUMW - 1);
   localparam logic signed [EXPONENT+1:0] NORM_OFF = (EXPONENT + 2)'(MANTISSA + 2);
   localparam logic signed [EXPONENT+1:0] EXP_ZERO = {(EXPONENT + 2){1'b0}};
   localparam logic signed [EXPONENT+1:0] EXP_MAX  = {2'b00, {EXPONENT{1'b1}}};

   function automatic logic [PW-1:0] lead_one(input logic [SUMW-1:0] v);
      lead_one = {PW{1'b0}};
      for (int i = 0; i < SUMW; i++) begin
         if (v[i]) lead_one = i[PW-1:0];
      end
   endfunction

   logic en_s;
   logic v1_r, v2_r, out_valid_r;
   logic sign_s, zero_s;
   logic [SUMW-1:0] mag_s;
   logic [PW-1:0] p_s;
   logic sign1_r, zero1_r;
   logic [SUMW-1:0] mag1_r;
   logic [PW-1:0] p1_r;
   logic [EXPONENT-1:0] mexp1_r;
   logic [PW-1:0] shamt_s;
   logic [SUMW-1:0] norm_s;
   logic [MANTISSA-1:0] mant2_s, mant2_r;
   logic signed [EXPONENT+1:0] exp2_s, exp2_r;
   logic sign2_r, zero2_r;
   logic [MANTISSA-1:0] mant3_s;
   logic signed [EXPONENT+1:0] exp3_s;
   logic [RW-1:0] res_s, result_r;
   logic fz_s, fo_s, fu_s, fz_r, fo_r, fu_r;

   assign en_s      = ~out_valid_r | out_ready;
   assign in_ready  = en_s;
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign flag_zero = fz_r;
   assign flag_ovf  = fo_r;
   assign flag_unf  = fu_r;

   // Stage 1 combinational: sign, magnitude and leading-one position
   always_comb begin
      sign_s = sum[SUMW-1];
      if (sign_s) begin
         mag_s = ~sum + {{(SUMW-1){1'b0}}, 1'b1};
      end else begin
         mag_s = sum;
      end
      p_s    = lead_one(mag_s);
      zero_s = (mag_s == {SUMW{1'b0}});
   end

   // Stage 2 combinational: leading one moved to the top bit, exponent rebased on it
   always_comb begin
      shamt_s = TOP_IDX - p1_r;
      norm_s  = mag1_r << shamt_s;
      mant2_s = norm_s[SUMW-2 -: MANTISSA];
      exp2_s  = $signed({2'b00, mexp1_r}) + $signed({{(EXPONENT + 2 - PW){1'b0}}, p1_r}) - NORM_OFF;
   end

`ifdef FP_NORM_ROUND_EN
   logic g_s, st_s, g2_r, st2_r, round_s;
   logic [MANTISSA:0] mant_sum_s;
   logic norm_unused_s;
   assign g_s  = norm_s[SUMW-2-MANTISSA];
   assign st_s = |norm_s[SUMW-3-MANTISSA:0];
   assign norm_unused_s = norm_s[SUMW-1];

   // Guard and sticky bits travel alongside the stage-2 mantissa
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         g2_r  <= 1'b0;
         st2_r <= 1'b0;
      end else if (en_s && v1_r) begin
         g2_r  <= g_s;
         st2_r <= st_s;
      end
   end
`else
   logic [SUMW-MANTISSA-1:0] norm_unused_s;
   assign norm_unused_s = {norm_s[SUMW-1], norm_s[SUMW-2-MANTISSA:0]};
`endif

   // Stage 3 combinational: rounding, then zero/underflow/overflow priority and packing
   always_comb begin
      mant3_s = mant2_r;
      exp3_s  = exp2_r;
      res_s   = {RW{1'b0}};
      fz_s    = 1'b0;
      fo_s    = 1'b0;
      fu_s    = 1'b0;
`ifdef FP_NORM_ROUND_EN
      round_s    = g2_r & (st2_r | mant2_r[0]);
      mant_sum_s = {1'b0, mant2_r} + {{MANTISSA{1'b0}}, round_s};
      if (mant_sum_s[MANTISSA]) begin
         mant3_s = {MANTISSA{1'b0}};
         exp3_s  = exp2_r + {{(EXPONENT + 1){1'b0}}, 1'b1};
      end else begin
         mant3_s = mant_sum_s[MANTISSA-1:0];
         exp3_s  = exp2_r;
      end
`endif
      if (zero2_r) begin
         res_s = {RW{1'b0}};
         fz_s  = 1'b1;
      end else if (exp3_s <= EXP_ZERO) begin
         res_s = {sign2_r, {(RW - 1){1'b0}}};
         fu_s  = 1'b1;
      end else if (exp3_s >= EXP_MAX) begin
         res_s = {sign2_r, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
         fo_s  = 1'b1;
      end else begin
         res_s = {sign2_r, exp3_s[EXPONENT-1:0], mant3_s};
      end
   end

   // Pipeline registers; all stages advance together when the output slot is free
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_r        <= 1'b0;
         v2_r        <= 1'b0;
         out_valid_r <= 1'b0;
         sign1_r     <= 1'b0;
         zero1_r     <= 1'b0;
         mag1_r      <= {SUMW{1'b0}};
         p1_r        <= {PW{1'b0}};
         mexp1_r     <= {EXPONENT{1'b0}};
         sign2_r     <= 1'b0;
         zero2_r     <= 1'b0;
         mant2_r     <= {MANTISSA{1'b0}};
         exp2_r      <= {(EXPONENT + 2){1'b0}};
         result_r    <= {RW{1'b0}};
         fz_r        <= 1'b0;
         fo_r        <= 1'b0;
         fu_r        <= 1'b0;
      end else if (en_s) begin
         v1_r        <= in_valid;
         v2_r        <= v1_r;
         out_valid_r <= v2_r;
         if (in_valid) begin
            sign1_r <= sign_s;
            zero1_r <= zero_s;
            mag1_r  <= mag_s;
            p1_r    <= p_s;
            mexp1_r <= max_exp;
         end
         if (v1_r) begin
            sign2_r <= sign1_r;
            zero2_r <= zero1_r;
            mant2_r <= mant2_s;
            exp2_r  <= exp2_s;
         end
         if (v2_r) begin
            result_r <= res_s;
            fz_r     <= fz_s;
            fo_r     <= fo_s;
            fu_r     <= fu_s;
         end
      end
   end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Directed scoreboard bench for fp_norm_pack (default parameters E=8, M=23, SUMW=29).
module tb_fp_norm_pack;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [28:0] sum;
   logic [7:0]  max_exp;
   logic [31:0] result;
   logic        flag_zero, flag_ovf, flag_unf;

   int total = 0;
   int bad   = 0;
   logic [34:0] exp_q[$];
   string       tag_q[$];
   logic [34:0] mon_e;
   string       mon_t;
   logic [34:0] held;

`ifdef FP_NORM_ROUND_EN
   localparam logic [31:0] R_TIE = 32'h3F800002;
   localparam logic [31:0] R_CRY = 32'h40000000;
`else
   localparam logic [31:0] R_TIE = 32'h3F800001;
   localparam logic [31:0] R_CRY = 32'h3FFFFFFF;
`endif

   always #5 clk = ~clk;

   fp_norm_pack dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .sum(sum), .max_exp(max_exp), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flag_zero(flag_zero), .flag_ovf(flag_ovf), .flag_unf(flag_unf)
   );

   task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic send(input string tag, input logic [28:0] s, input logic [7:0] e,
                       input logic [31:0] r, input logic zf, input logic of, input logic uf);
      int n;
      sum = s; max_exp = e; in_valid = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      total++;
      assert (in_ready === 1'b1) else begin
         bad++;
         $error("FAIL %s_accept observed in_ready=%b expected=1", tag, in_ready);
      end
      exp_q.push_back({r, zf, of, uf});
      tag_q.push_back(tag);
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk); n++;
      end
      total++;
      assert (exp_q.size() == 0) else begin
         bad++;
         $error("FAIL %s_drain observed pending=%0d expected=0", tag, exp_q.size());
      end
   endtask

   // Output monitor: a result is consumed when out_valid and out_ready meet at a clock edge
   always @(negedge clk) begin
      #1;
      if (rst_n && out_valid && out_ready) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_output observed=%h expected=none", result);
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            chk(mon_t, {result, flag_zero, flag_ovf, flag_unf}, mon_e);
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sum = 29'h0; max_exp = 8'h0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_state", {out_valid, result, flag_zero, flag_ovf, flag_unf}, 35'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", {34'h0, in_ready}, {34'h0, 1'b1});

      // First result latency
      send("one", 29'h2000000, 8'd127, 32'h3F800000, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle2", {34'h0, out_valid}, {34'h0, 1'b0});
      @(negedge clk);
      chk("lat_cycle3", {34'h0, out_valid}, {34'h0, 1'b1});
      drain("latency");

      // Directed values, back to back
      send("three",   29'h2000000 * 29'd3, 8'd127, 32'h40400000, 1'b0, 1'b0, 1'b0);
      send("neg_one", 29'h1E000000,        8'd127, 32'hBF800000, 1'b0, 1'b0, 1'b0);
      send("zero",    29'h0,               8'd127, 32'h00000000, 1'b1, 1'b0, 1'b0);
      send("ovf",     29'h4000000,         8'd254, 32'h7F800000, 1'b0, 1'b1, 1'b0);
      send("unf",     29'h1000000,         8'd1,   32'h00000000, 1'b0, 1'b0, 1'b1);
      send("rnd_dn",  29'h2000001,         8'd127, 32'h3F800000, 1'b0, 1'b0, 1'b0);
      send("rnd_tie", 29'h2000006,         8'd127, R_TIE,        1'b0, 1'b0, 1'b0);
      send("rnd_cry", 29'h3FFFFFE,         8'd127, R_CRY,        1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      drain("directed");

      // Backpressure: six inputs streamed while the output stalls for five cycles
      fork
         begin
            send("bp0", 29'h2000000,  8'd127, 32'h3F800000, 1'b0, 1'b0, 1'b0);
            send("bp1", 29'h6000000,  8'd127, 32'h40400000, 1'b0, 1'b0, 1'b0);
            send("bp2", 29'h1E000000, 8'd127, 32'hBF800000, 1'b0, 1'b0, 1'b0);
            send("bp3", 29'h2000001,  8'd127, 32'h3F800000, 1'b0, 1'b0, 1'b0);
            send("bp4", 29'h2000006,  8'd127, R_TIE,        1'b0, 1'b0, 1'b0);
            send("bp5", 29'h3FFFFFE,  8'd127, R_CRY,        1'b0, 1'b0, 1'b0);
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(negedge clk);
            out_ready = 1'b0;
            #1;
            held = {result, flag_zero, flag_ovf, flag_unf};
            chk("stall_start", {33'h0, out_valid, in_ready}, {33'h0, 2'b10});
            for (int k = 0; k < 4; k++) begin
               @(negedge clk); #1;
               chk("stall_ready", {33'h0, out_valid, in_ready}, {33'h0, 2'b10});
               chk("stall_hold", {result, flag_zero, flag_ovf, flag_unf}, held);
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain("backpressure");

      // Reset with two results in flight
      send("rst_a", 29'h2000000, 8'd127, 32'h3F800000, 1'b0, 1'b0, 1'b0);
      send("rst_b", 29'h6000000, 8'd127, 32'h40400000, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("flush_out", {out_valid, result, flag_zero, flag_ovf, flag_unf}, 35'h0);
      chk("flush_in_ready", {34'h0, in_ready}, {34'h0, 1'b1});
      exp_q.delete();
      tag_q.delete();
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      send("post_rst", 29'h1E000000, 8'd127, 32'hBF800000, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      drain("post_reset");
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
